// File: rtl/tile_prog_pkg.sv
// Shared state encoding and elaboration-time helpers for the tile bank
// programming controller.
package tile_prog_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD
   } prog_state_t;

   function automatic int words_f(input int num_bl, input int data_w);
      return (num_bl + data_w - 1) / data_w;
   endfunction

   // Never returns less than 1 so a degenerate counter still gets a real bit.
   function automatic int clog2_f(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/prog_chain_pipe.sv
// Generic reset-to-zero register pipeline used for the inter-tile bl/wl
// chains; DEPTH=0 collapses to a plain wire.
module prog_chain_pipe #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             prog_clk,
   input  logic             prog_reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign dout = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge prog_clk) begin
            if (prog_reset) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/tile_bank_prog_ctrl.sv
// Per-tile memory-bank programming controller: assembles a bitline vector from
// a framed word stream, then fires a timed one-hot wordline pulse on one row.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for word 0; captures the target row
//   ST_LOAD  | collecting words 1..WORDS-1
//   ST_SETUP | one cycle of bl settling, wl low
//   ST_PULSE | wl[row] high, down-counter times PULSE_CYC cycles
//   ST_HOLD  | wl low, bl held, frame_done strobe
module tile_bank_prog_ctrl
   import tile_prog_pkg::*;
#(
   parameter int NUM_BL     = 160,
   parameter int NUM_WL     = 160,
   parameter int DATA_W     = 32,
   parameter int ROW_W      = 8,
   parameter int PULSE_CYC  = 2,
   parameter int BL_CHAIN_W = 315,
   parameter int WL_CHAIN_W = 4,
   parameter int CHAIN_PIPE = 1
) (
   input  logic                  prog_clk,
   input  logic                  prog_reset,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [DATA_W-1:0]     cfg_data,
   input  logic [ROW_W-1:0]      cfg_row,
   input  logic                  cfg_last,
   output logic [NUM_BL-1:0]     bl,
   output logic [NUM_WL-1:0]     wl,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  err,
   input  logic                  err_clr,
   input  logic [BL_CHAIN_W-1:0] bl_in,
   output logic [BL_CHAIN_W-1:0] bl_out,
   input  logic [WL_CHAIN_W-1:0] wl_in,
   output logic [WL_CHAIN_W-1:0] wl_out
);

   localparam int WORDS = words_f(NUM_BL, DATA_W);
   localparam int CNT_W = clog2_f(WORDS);
   localparam int PC_W  = clog2_f(PULSE_CYC);

   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WORDS - 1);
   localparam logic [PC_W-1:0]  PULSE_LD  = PC_W'(PULSE_CYC - 1);
   localparam logic [ROW_W:0]   ROW_LIMIT = (ROW_W + 1)'(NUM_WL);

   prog_state_t         state;
   logic [CNT_W-1:0]    cnt;
   logic [ROW_W-1:0]    row_q;
   logic [PC_W-1:0]     pulse_cnt;

   logic                xfer;
   logic [CNT_W-1:0]    wr_idx;
   logic                word_err;
   logic [ROW_W-1:0]    row_chk;
   logic                row_bad;
   logic [NUM_BL-1:0]   bl_nxt;

   assign cfg_ready = (state == ST_IDLE) || (state == ST_LOAD);
   assign busy      = (state != ST_IDLE);
   assign xfer      = cfg_valid && cfg_ready;
   assign wr_idx    = (state == ST_IDLE) ? '0 : cnt;

   // cfg_last must coincide exactly with the final word of the frame.
   assign word_err  = (wr_idx == LAST_IDX) ? !cfg_last : cfg_last;

   // With a single-word frame the row is still on the bus when SETUP is entered.
   assign row_chk   = (state == ST_IDLE) ? cfg_row : row_q;
   assign row_bad   = {1'b0, row_chk} >= ROW_LIMIT;

   // Bits of the last word that fall past NUM_BL are simply never stored.
   for (genvar w = 0; w < WORDS; w++) begin : g_word
      localparam int LO  = w * DATA_W;
      localparam int LEN = (NUM_BL - LO < DATA_W) ? (NUM_BL - LO) : DATA_W;
      localparam logic [CNT_W-1:0] IDX = CNT_W'(w);

      assign bl_nxt[LO +: LEN] = (wr_idx == IDX) ? cfg_data[LEN-1:0] : bl[LO +: LEN];
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         row_q      <= '0;
         pulse_cnt  <= '0;
         bl         <= '0;
         wl         <= '0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (err_clr) err <= 1'b0;
         if (xfer) bl <= bl_nxt;

         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  row_q <= cfg_row;
                  cnt   <= CNT_W'(1);
                  if (word_err) begin
                     err   <= 1'b1;
                     cnt   <= '0;
                  end else if (cfg_last) begin
                     cnt <= '0;
                     if (row_bad) err   <= 1'b1;
                     else         state <= ST_SETUP;
                  end else begin
                     state <= ST_LOAD;
                  end
               end
            end

            ST_LOAD: begin
               if (xfer) begin
                  if (word_err) begin
                     err   <= 1'b1;
                     cnt   <= '0;
                     state <= ST_IDLE;
                  end else if (cfg_last) begin
                     cnt <= '0;
                     if (row_bad) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                     end else begin
                        state <= ST_SETUP;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end

            ST_SETUP: begin
               wl        <= NUM_WL'(1) << row_q;
               pulse_cnt <= PULSE_LD;
               state     <= ST_PULSE;
            end

            ST_PULSE: begin
               if (pulse_cnt == '0) begin
                  wl         <= '0;
                  frame_done <= 1'b1;
                  state      <= ST_HOLD;
               end else begin
                  pulse_cnt <= pulse_cnt - PC_W'(1);
               end
            end

            ST_HOLD: begin
               state <= ST_IDLE;
            end

            default: begin
               wl    <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   prog_chain_pipe #(
      .WIDTH (BL_CHAIN_W),
      .DEPTH (CHAIN_PIPE)
   ) u_bl_chain (
      .prog_clk   (prog_clk),
      .prog_reset (prog_reset),
      .din        (bl_in),
      .dout       (bl_out)
   );

   prog_chain_pipe #(
      .WIDTH (WL_CHAIN_W),
      .DEPTH (CHAIN_PIPE)
   ) u_wl_chain (
      .prog_clk   (prog_clk),
      .prog_reset (prog_reset),
      .din        (wl_in),
      .dout       (wl_out)
   );

endmodule

// File: tb/tb_tile_bank_prog_ctrl.sv
// Bench for tile_bank_prog_ctrl: frame scoreboard, pulse timing, error paths,
// mid-pulse reset and chain pass-through.
module tb_tile_bank_prog_ctrl;

   localparam int NUM_BL = 160;
   localparam int NUM_WL = 160;
   localparam int DATA_W = 32;
   localparam int ROW_W  = 8;
   localparam int BLC    = 315;
   localparam int WLC    = 4;

   logic              prog_clk = 1'b0;
   logic              prog_reset;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [DATA_W-1:0] cfg_data;
   logic [ROW_W-1:0]  cfg_row;
   logic              cfg_last;
   logic [NUM_BL-1:0] bl;
   logic [NUM_WL-1:0] wl;
   logic              busy;
   logic              frame_done;
   logic              err;
   logic              err_clr;
   logic [BLC-1:0]    bl_in;
   logic [BLC-1:0]    bl_out;
   logic [WLC-1:0]    wl_in;
   logic [WLC-1:0]    wl_out;

   always #5 prog_clk = ~prog_clk;

   tile_bank_prog_ctrl #(
      .NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .DATA_W(DATA_W), .ROW_W(ROW_W),
      .PULSE_CYC(2), .BL_CHAIN_W(BLC), .WL_CHAIN_W(WLC), .CHAIN_PIPE(1)
   ) dut (
      .prog_clk(prog_clk), .prog_reset(prog_reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
      .cfg_row(cfg_row), .cfg_last(cfg_last),
      .bl(bl), .wl(wl), .busy(busy), .frame_done(frame_done),
      .err(err), .err_clr(err_clr),
      .bl_in(bl_in), .bl_out(bl_out), .wl_in(wl_in), .wl_out(wl_out)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk_eq(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NUM_WL-1:0] onehot(input logic [ROW_W-1:0] r);
      return NUM_WL'(1) << r;
   endfunction

   function automatic logic [NUM_BL-1:0] rand_pat();
      logic [NUM_BL-1:0] p;
      p = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return p;
   endfunction

   typedef struct {
      logic [NUM_BL-1:0] bl;
      logic [ROW_W-1:0]  row;
   } sb_t;

   sb_t exp_q[$];
   sb_t sb_mon;
   int  wl_seen = 0;
   logic [NUM_WL-1:0] wl_last = '0;

   // Scoreboard side: frame_done pops the expected bitline vector and row.
   always @(negedge prog_clk) begin
      if (prog_reset === 1'b0) begin
         if (wl != '0) begin
            wl_seen++;
            wl_last = wl;
         end
         if (frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk_eq("sb_unexpected_done", frame_done, 1'b0);
            end else begin
               sb_mon = exp_q.pop_front();
               chk_eq("sb_bl", bl, sb_mon.bl);
               chk_eq("sb_wl_row", wl_last, onehot(sb_mon.row));
            end
         end
      end
   end

   // Chain model: one register stage, cleared by reset.
   logic [BLC-1:0] bl_chain_exp = '0;
   logic [WLC-1:0] wl_chain_exp = '0;
   bit             chain_en = 1'b0;
   int             chain_cyc = 0;
   logic [319:0]   rnd320;

   always @(posedge prog_clk) begin
      bl_chain_exp = prog_reset ? '0 : bl_in;
      wl_chain_exp = prog_reset ? '0 : wl_in;
   end

   always @(negedge prog_clk) begin
      if (chain_en) begin
         chk_eq("bl_chain", bl_out, bl_chain_exp);
         chk_eq("wl_chain", wl_out, wl_chain_exp);
         chain_cyc++;
         if (chain_cyc > 16) begin
            rnd320 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            bl_in  = rnd320[BLC-1:0];
            wl_in  = 4'($urandom_range(0, 15));
         end
      end
   end

   task automatic send_word(input logic [DATA_W-1:0] d, input logic [ROW_W-1:0] r, input bit last);
      int t;
      t = 0;
      @(negedge prog_clk);
      cfg_valid = 1'b1;
      cfg_data  = d;
      cfg_row   = r;
      cfg_last  = last;
      while (!cfg_ready && t < 50) begin
         @(negedge prog_clk);
         t++;
      end
      if (t >= 50) chk_eq("ready_timeout", cfg_ready, 1'b1);
      @(posedge prog_clk);
      #1;
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
   endtask

   task automatic good_frame(input logic [ROW_W-1:0] r, input logic [NUM_BL-1:0] pat,
                             input bit gap, input bit junk);
      sb_t e;
      e.bl  = pat;
      e.row = r;
      exp_q.push_back(e);
      for (int k = 0; k < 5; k++) begin
         if (gap && k > 0) begin
            @(posedge prog_clk);
            #1;
         end
         send_word(pat[k*DATA_W +: DATA_W], r, k == 4);
      end
      if (junk) begin
         cfg_valid = 1'b1;
         cfg_data  = '1;
         cfg_row   = '0;
         cfg_last  = 1'b1;
      end
      @(negedge prog_clk);
      chk_eq("setup_wl", wl, '0);
      chk_eq("setup_ready", cfg_ready, 1'b0);
      chk_eq("setup_busy", busy, 1'b1);
      @(negedge prog_clk);
      chk_eq("pulse1_wl", wl, onehot(r));
      chk_eq("pulse1_ready", cfg_ready, 1'b0);
      @(negedge prog_clk);
      chk_eq("pulse2_wl", wl, onehot(r));
      chk_eq("pulse2_done", frame_done, 1'b0);
      @(negedge prog_clk);
      chk_eq("hold_wl", wl, '0);
      chk_eq("hold_done", frame_done, 1'b1);
      chk_eq("hold_ready", cfg_ready, 1'b0);
      cfg_valid = 1'b0;
      @(negedge prog_clk);
      chk_eq("idle_done", frame_done, 1'b0);
      chk_eq("idle_ready", cfg_ready, 1'b1);
      chk_eq("idle_busy", busy, 1'b0);
   endtask

   // last_at < 0 sends all five words without cfg_last.
   task automatic err_frame(input logic [ROW_W-1:0] r, input int last_at, input logic [NUM_BL-1:0] pat);
      int n;
      int base;
      n = (last_at < 0) ? 5 : last_at + 1;
      for (int k = 0; k < n; k++) send_word(pat[k*DATA_W +: DATA_W], r, k == last_at);
      base = wl_seen;
      @(negedge prog_clk);
      chk_eq("errf_err", err, 1'b1);
      chk_eq("errf_busy", busy, 1'b0);
      chk_eq("errf_ready", cfg_ready, 1'b1);
      repeat (6) @(negedge prog_clk);
      chk_eq("errf_no_wl", wl_seen - base, 0);
   endtask

   task automatic clear_err();
      @(negedge prog_clk);
      err_clr = 1'b1;
      @(negedge prog_clk);
      err_clr = 1'b0;
      chk_eq("err_cleared", err, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [NUM_BL-1:0] pat;

      prog_reset = 1'b1;
      cfg_valid  = 1'b0;
      cfg_data   = '0;
      cfg_row    = '0;
      cfg_last   = 1'b0;
      err_clr    = 1'b0;
      bl_in      = BLC'(16'h1234);
      wl_in      = 4'b1010;
      repeat (3) @(posedge prog_clk);
      #1;
      prog_reset = 1'b0;

      @(negedge prog_clk);
      chk_eq("rst_bl", bl, '0);
      chk_eq("rst_wl", wl, '0);
      chk_eq("rst_busy", busy, 1'b0);
      chk_eq("rst_done", frame_done, 1'b0);
      chk_eq("rst_err", err, 1'b0);
      chk_eq("rst_ready", cfg_ready, 1'b1);
      chain_en = 1'b1;

      pat = {5{32'hA5A5_A5A5}};
      good_frame(8'd7, pat, 1'b0, 1'b0);
      chk_eq("nominal_err", err, 1'b0);

      pat = {32'h5555_0004, 32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
      good_frame(8'd42, pat, 1'b1, 1'b1);

      good_frame(8'd159, rand_pat(), 1'b0, 1'b0);
      good_frame(8'd0, rand_pat(), 1'b1, 1'b0);

      err_frame(8'd9, 2, rand_pat());
      good_frame(8'd3, rand_pat(), 1'b0, 1'b0);
      chk_eq("err_sticky", err, 1'b1);
      clear_err();

      err_frame(8'd9, -1, rand_pat());
      clear_err();

      err_frame(8'd200, 4, rand_pat());
      chk_eq("row_bad_no_done", exp_q.size(), 0);
      clear_err();

      @(negedge prog_clk);
      err_clr = 1'b1;
      err_frame(8'd1, 1, rand_pat());
      err_clr = 1'b0;

      pat = rand_pat();
      for (int k = 0; k < 5; k++) send_word(pat[k*DATA_W +: DATA_W], 8'd5, k == 4);
      @(negedge prog_clk);
      @(negedge prog_clk);
      chk_eq("rst_pre_wl", wl, onehot(8'd5));
      prog_reset = 1'b1;
      @(negedge prog_clk);
      prog_reset = 1'b0;
      chk_eq("midrst_wl", wl, '0);
      chk_eq("midrst_bl", bl, '0);
      chk_eq("midrst_busy", busy, 1'b0);
      chk_eq("midrst_ready", cfg_ready, 1'b1);
      chk_eq("midrst_err", err, 1'b0);

      good_frame(8'd100, rand_pat(), 1'b0, 1'b0);

      repeat (3) @(negedge prog_clk);
      chk_eq("sb_drain", exp_q.size(), 0);
      chain_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tile_bank_prog_ctrl.md
Name: tile_bank_prog_ctrl

Overview:
- Per-tile memory-bank programming controller. Replaces the static bl/wl buses that currently flow into a tile's connection and switch blocks.
- Accepts configuration frames over a valid/ready word stream and assembles a full bitline vector.
- Drives a timed, one-hot wordline pulse on the addressed row.
- Forwards the inter-tile bl/wl chains through a parametrised register pipeline to the neighbouring tile.

Parameters:
- NUM_BL, 160, bitlines driven into the tile's CB/SB memories.
- NUM_WL, 160, wordlines (rows) in the tile.
- DATA_W, 32, cfg_data word width.
- ROW_W, 8, cfg_row width; must satisfy 2**ROW_W >= NUM_WL.
- PULSE_CYC, 2, cycles wl is held high; minimum 1.
- BL_CHAIN_W, 315, width of the pass-through bitline chain.
- WL_CHAIN_W, 4, width of the pass-through wordline chain.
- CHAIN_PIPE, 1, register stages on the pass-through chains; 0 means combinational.

Ports:
- prog_clk  input  1  programming clock.
- prog_reset  input  1  reset, synchronous to prog_clk, active-high (already decided).
- cfg_valid  input  1  word valid.
- cfg_ready  output  1  controller accepts a word.
- cfg_data  input  DATA_W  bitline data word.
- cfg_row  input  ROW_W  target row; sampled only on the first word of a frame.
- cfg_last  input  1  marks the final word of a frame.
- bl  output  NUM_BL  bitline vector to the tile memories.
- wl  output  NUM_WL  one-hot wordline pulse.
- busy  output  1  a frame is in flight.
- frame_done  output  1  single-cycle strobe after a successful write.
- err  output  1  sticky error flag.
- err_clr  input  1  clears err.
- bl_in  input  BL_CHAIN_W  upstream bitline chain.
- bl_out  output  BL_CHAIN_W  downstream bitline chain.
- wl_in  input  WL_CHAIN_W  upstream wordline chain.
- wl_out  output  WL_CHAIN_W  downstream wordline chain.

Behaviour:
- Reset (prog_reset high at a prog_clk edge) clears everything: bl=0, wl=0, busy=0, frame_done=0, err=0, word counter=0, row register=0, all chain pipeline registers=0, state=IDLE. Reset asserted mid-frame aborts the frame with no wl pulse.
- WORDS = ceil(NUM_BL/DATA_W). A transfer occurs when cfg_valid && cfg_ready.
- Word k (0-based) writes bl[k*DATA_W +: DATA_W]. Bits at or above NUM_BL are discarded. Bits not yet written keep their previous frame value.
- FSM states:
  - IDLE: cfg_ready=1. A transfer captures cfg_row and word 0, then moves to LOAD. If WORDS==1 and cfg_last is set, it moves straight to SETUP.
  - LOAD: cfg_ready=1, busy=1. Each transfer increments the counter. A transfer with cfg_last on word WORDS-1 moves to SETUP.
  - SETUP: cfg_ready=0. One cycle of bl settling; wl stays 0.
  - PULSE: wl[row]=1 for exactly PULSE_CYC cycles; all other wl bits are 0.
  - HOLD: one cycle, wl=0, bl held. frame_done=1 in this cycle. Next state is IDLE.
- Errors: the frame is dropped (no pulse), err is set, and the FSM goes to IDLE on the same edge. Error cases:
  - cfg_last arrives on word index < WORDS-1;
  - word index WORDS-1 arrives without cfg_last;
  - the captured row >= NUM_WL (checked on entry to SETUP).
- err is sticky. err_clr clears it. If an error and err_clr occur in the same cycle, set wins.
- Latency: from the last-word transfer, wl rises 2 edges later and stays high for PULSE_CYC cycles. frame_done comes PULSE_CYC+2 cycles after the last word. The next frame can be accepted in the cycle after HOLD.
- busy=1 in every state except IDLE.
- Chains: bl_out/wl_out equal bl_in/wl_in delayed by CHAIN_PIPE prog_clk cycles. The chains are independent of the FSM.

Decomposition:
- Package tile_prog_pkg holds:
  - state enum (IDLE, LOAD, SETUP, PULSE, HOLD);
  - the WORDS computation function;
  - a clog2 helper for the word counter and the pulse counter.
- Sub-module prog_chain_pipe: a generic WIDTH/DEPTH register pipeline, instantiated twice (bl chain, wl chain). It resets to 0 and is a pure wire at DEPTH=0.

Test Plan (NUM_BL=160, DATA_W=32, WORDS=5, PULSE_CYC=2, CHAIN_PIPE=1):
- Nominal frame: row=7, five words 0xA5A5A5A5 with no stalls, cfg_last on word 4 -> bl = 160 bits of the A5 pattern; wl[7]=1 for exactly cycles +2 and +3 after the last word; frame_done at +4; err=0.
- Backpressure and gaps: cfg_valid toggles every other cycle -> same result. cfg_ready=0 from SETUP through HOLD; no word is accepted during those states.
- Early last: cfg_last on word 2 -> err=1, wl stays 0 throughout, FSM back in IDLE. The next valid frame to row 3 succeeds; err stays 1 until err_clr.
- Row out of range: row=200 with a full, well-formed frame -> err=1, no wl bit ever asserts, frame_done=0.
- Mid-pulse reset: assert prog_reset during the first PULSE cycle -> next cycle wl=0, bl=0, busy=0, cfg_ready=1.
- Chain pass-through: drive bl_in=0x1234 and wl_in=4'b1010 while frames run -> bl_out/wl_out equal those values exactly 1 cycle later, unaffected by FSM activity.
